jt49_mixer: RTL

- Post-PSG mixing stage. Consumes the three linearised channel outputs A, B and C of the PSG core.
- Applies a per-channel 8-bit gain using one shared, time-multiplexed multiplier, and sums the three products.
- Optionally removes DC with a first-order leaky integrator.
- Delivers a signed 16-bit sample with a one-cycle valid strobe to the downstream audio path (resampler or DAC).

---
 rtl/jt49_mix_pkg.sv | 31 +++
 rtl/jt49_dcrm.sv | 35 +++
 rtl/jt49_mixer.sv | 105 ++++++++++
 3 files changed

// File: rtl/jt49_mix_pkg.sv
// Shared types, widths and the output saturation helper for the jt49 mixer.
package jt49_mix_pkg;

    localparam int unsigned SUMW  = 14;
    localparam int unsigned PRODW = 16;
    localparam int unsigned OUTW  = 16;
    localparam int unsigned GFRAC = 4;
    localparam int unsigned WIDEW = 18;

    typedef enum logic [2:0] {
        StIdle,
        StMulA,
        StMulB,
        StMulC,
        StDcrm,
        StOut
    } state_t;

    localparam logic signed [WIDEW-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [WIDEW-1:0] SAT_MIN = -18'sd32768;

    function automatic logic signed [OUTW-1:0] sat16(input logic signed [WIDEW-1:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7fff;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end
        return v[OUTW-1:0];
    endfunction

endpackage

// File: rtl/jt49_dcrm.sv
// Leaky-integrator DC tracker: y = x - dc, and dc moves 1/2^DCW of the way towards x on step.
module jt49_dcrm
    import jt49_mix_pkg::*;
#(
    parameter int unsigned DCW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step,
    input  logic [SUMW-1:0]        x,
    output logic signed [SUMW:0]   y
);

    localparam int unsigned FW = SUMW + DCW + 2;

    logic signed [FW-1:0]   dc_full;
    logic signed [FW-1:0]   x_full;
    logic signed [FW-1:0]   delta;
    logic signed [SUMW:0]   dc;

    assign x_full = $signed({2'b00, x, {DCW{1'b0}}});
    assign delta  = (x_full - dc_full) >>> DCW;
    // dc_full never goes negative, so the integer slice is a valid signed value
    assign dc     = $signed(dc_full[SUMW+DCW:DCW]);
    assign y      = $signed({1'b0, x}) - dc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_full <= '0;
        end else if (step) begin
            dc_full <= dc_full + delta;
        end
    end

endmodule

// File: rtl/jt49_mixer.sv
// Three-channel gain/mix stage with a shared multiplier and optional DC removal
// (enabled by defining JT49_MIXER_DCRM_EN).
module jt49_mixer
    import jt49_mix_pkg::*;
#(
    parameter int unsigned DCW   = 8,
    parameter int unsigned OUTSH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic [7:0]             A,
    input  logic [7:0]             B,
    input  logic [7:0]             C,
    input  logic [7:0]             gainA,
    input  logic [7:0]             gainB,
    input  logic [7:0]             gainC,
    output logic signed [OUTW-1:0] snd,
    output logic                   sample,
    output logic                   drop
);

    state_t                 state;
    logic [7:0]             a_h, b_h, c_h, ga_h, gb_h, gc_h;
    logic [7:0]             mul_a, mul_g;
    logic [PRODW-1:0]       prod;
    logic [SUMW-1:0]        term;
    logic [SUMW-1:0]        sum;
    logic signed [SUMW:0]   y;
    logic signed [WIDEW-1:0] y_sh;

    always_comb begin
        mul_a = a_h;
        mul_g = ga_h;
        case (state)
            StMulB:  begin mul_a = b_h; mul_g = gb_h; end
            StMulC:  begin mul_a = c_h; mul_g = gc_h; end
            default: ;
        endcase
    end

    assign prod = PRODW'(mul_a) * PRODW'(mul_g);
    assign term = SUMW'(prod >> GFRAC);
    assign y_sh = WIDEW'(y) <<< OUTSH;
    assign drop = cen && (state != StIdle);

`ifdef JT49_MIXER_DCRM_EN
    jt49_dcrm #(
        .DCW (DCW)
    ) u_dcrm (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (state == StDcrm),
        .x     (sum),
        .y     (y)
    );
`else
    logic unused_dcw;
    assign unused_dcw = ^DCW;
    assign y          = $signed({1'b0, sum});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            a_h    <= '0;
            b_h    <= '0;
            c_h    <= '0;
            ga_h   <= '0;
            gb_h   <= '0;
            gc_h   <= '0;
            sum    <= '0;
            snd    <= '0;
            sample <= 1'b0;
        end else begin
            sample <= 1'b0;
            case (state)
                StIdle: begin
                    if (cen) begin
                        a_h   <= A;
                        b_h   <= B;
                        c_h   <= C;
                        ga_h  <= gainA;
                        gb_h  <= gainB;
                        gc_h  <= gainC;
                        sum   <= '0;
                        state <= StMulA;
                    end
                end
                StMulA: begin sum <= sum + term; state <= StMulB; end
                StMulB: begin sum <= sum + term; state <= StMulC; end
                StMulC: begin sum <= sum + term; state <= StDcrm; end
                // Registered here so the pulse lands in the OUT cycle
                StDcrm: begin
                    snd    <= sat16(y_sh);
                    sample <= 1'b1;
                    state  <= StOut;
                end
                StOut:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
